mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Execute-stage multiply/divide unit owning the HI/LO registers.
- Produces the `Busy` signal that the decode-stage stall controller combines with `D_MDInstr` to hold MD-class instructions (mult/div/mfhi/mflo/mthi/mtlo) in D.
- Multi-cycle: the result is computed at start, held in pending registers, and committed to HI/LO after a fixed latency.

Parameters:
- MULT_CYCLES, 5, busy cycles after the start cycle for MULT/MULTU.
- DIV_CYCLES, 10, busy cycles after the start cycle for DIV/DIVU.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- Start  input  1  E-stage MD instruction valid this cycle; qualifies MDOp.
- MDOp  input  3  0=NONE, 1=MULT, 2=MULTU, 3=DIV, 4=DIVU, 5=MTHI, 6=MTLO, 7=reserved (NONE).
- A  input  32  rs operand (forwarded E-stage value).
- B  input  32  rt operand (forwarded E-stage value).
- Busy  output  1  to the stall controller; high while an operation is in flight.
- HI  output  32  architectural HI register (MFHI source).
- LO  output  32  architectural LO register (MFLO source).

Behaviour:
- Reset (sync, has priority over everything):
  - HI=0, LO=0, cnt=0, pending registers=0.
  - Busy drops to 0 after the reset edge, except that Busy still follows a same-cycle Start because it is combinational.
  - Reset during an operation discards the pending result; HI/LO are not written.
- Start of an operation:
  - Start=1 with MDOp in 1..4 while cnt==0 starts an operation.
  - At that edge, compute the full result from A/B into pHI/pLO and load cnt with MULT_CYCLES or DIV_CYCLES.
- Countdown and commit:
  - cnt decrements by 1 every cycle while cnt!=0.
  - On the edge where cnt==1: HI<=pHI, LO<=pLO, cnt<=0.
- Busy is combinational: Busy = (Start & MDOp in 1..4) | (cnt!=0).
  - For an operation started in cycle T with latency N, Busy=1 in cycles T..T+N.
  - New HI/LO are visible from cycle T+N+1, the first cycle with Busy=0.
  - HI/LO keep their old values throughout cycles T..T+N.
- MTHI/MTLO:
  - With Start=1 and cnt==0: HI<=A (MTHI) or LO<=A (MTLO) at the edge.
  - The value is visible the next cycle. Busy is not raised.
- Start while cnt!=0 (any MDOp): ignored, with no effect on state or pending registers. The stall controller prevents this case; the unit must still be robust to it.
- MULT: {pHI,pLO} = signed(A) × signed(B), full 64 bits.
- MULTU: {pHI,pLO} = unsigned 64-bit product.
- DIV (signed):
  - pLO = quotient truncated toward zero.
  - pHI = remainder, with the sign of the dividend A.
  - Overflow case 0x80000000 / 0xFFFFFFFF: pLO=0x80000000, pHI=0.
- DIVU: unsigned quotient in pLO, remainder in pHI.
- Divide by zero (DIV or DIVU with B==0):
  - Busy timing is unchanged (full DIV_CYCLES).
  - The commit writes nothing: HI/LO retain their prior values.
- MDOp 0 or 7 with Start=1: no effect.
- Start=0: MDOp, A and B are don't-care.

Test Plan:
1. reset; Start=1 MULT A=0xFFFFFFFD(-3) B=5 in cycle 0 → Busy=1 cycles 0..5; cycle 6: Busy=0, HI=0xFFFFFFFF, LO=0xFFFFFFF1. During cycles 0..5, HI/LO stay 0.
2. MULTU A=0xFFFFFFFF B=0xFFFFFFFF → after 6 cycles HI=0xFFFFFFFE, LO=0x00000001.
3. DIV A=-7 (0xFFFFFFF9) B=2 → Busy=1 for 11 cycles; then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). Repeat with DIVU A=7 B=2 → LO=3, HI=1.
4. MTHI A=0x12345678, then DIV A=100 B=0 → Busy=1 for 11 cycles; afterwards HI=0x12345678 and LO=0 (unchanged). Also check DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
5. Start MULT A=2 B=3; in cycle 2, pulse Start DIV A=9 B=3 and Start MTLO A=0xAA → both ignored; cycle 6: HI=0, LO=6.
6. Start DIV A=10 B=3; assert reset in cycle 4 → cycle 5: Busy=0, HI=0, LO=0; no later commit occurs (monitor 15 cycles).

Source files
------------

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mult_div_unit
//  Purpose  : Execute-stage multiply/divide unit that owns the HI/LO registers.
//             The full result is computed in the start cycle and parked in
//             pending registers. It is committed to HI/LO after a fixed
//             latency. Busy tells the decode-stage stall logic that an
//             operation is in flight.
//  Ports    : clk    - rising-edge clock
//             reset  - synchronous, active-high reset
//             Start  - E-stage MD instruction valid (qualifies MDOp)
//             MDOp   - 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI,
//                      6 MTLO, 7 reserved (treated as NONE)
//             A, B   - rs / rt operands (forwarded E-stage values)
//             Busy   - high while an operation is starting or in flight
//             HI, LO - architectural HI/LO registers
//  Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] c_OP_MULT  = 3'd1;
    localparam logic [2:0] c_OP_MULTU = 3'd2;
    localparam logic [2:0] c_OP_DIV   = 3'd3;
    localparam logic [2:0] c_OP_DIVU  = 3'd4;
    localparam logic [2:0] c_OP_MTHI  = 3'd5;
    localparam logic [2:0] c_OP_MTLO  = 3'd6;

    localparam int c_CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(DIV_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_phi;
    logic [31:0]        r_plo;
    logic               r_pdz;      // pending divide-by-zero: commit is suppressed

    logic        w_is_mul;
    logic        w_is_div;
    logic        w_is_md;
    logic        w_idle;
    logic        w_div_zero;
    logic [31:0] w_b_safe;
    logic [63:0] w_smul;
    logic [63:0] w_umul;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_sq_mag;
    logic [31:0] w_sr_mag;
    logic [31:0] w_sq;
    logic [31:0] w_sr;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_p_hi;
    logic [31:0] w_p_lo;

    assign w_is_mul   = (MDOp == c_OP_MULT) || (MDOp == c_OP_MULTU);
    assign w_is_div   = (MDOp == c_OP_DIV)  || (MDOp == c_OP_DIVU);
    assign w_is_md    = w_is_mul || w_is_div;
    assign w_idle     = (r_cnt == '0);

    assign Busy = (Start && w_is_md) || !w_idle;
    assign HI   = r_hi;
    assign LO   = r_lo;

    // A zero divisor is replaced by 1 so the dividers never see it; the
    // resulting value is discarded at commit anyway.
    assign w_div_zero = (B == 32'd0);
    assign w_b_safe   = w_div_zero ? 32'd1 : B;

    // Low 64 bits of a 64x64 product are the exact 32x32 product for both
    // sign-extended and zero-extended operands.
    assign w_smul = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign w_umul = {32'd0, A} * {32'd0, B};

    // Signed divide via magnitudes. 0x80000000 negates to itself, which is
    // its correct unsigned magnitude, so the overflow case -2^31 / -1 falls
    // out naturally as quotient 0x80000000, remainder 0.
    assign w_a_mag  = A[31] ? (32'd0 - A) : A;
    assign w_b_mag  = w_b_safe[31] ? (32'd0 - w_b_safe) : w_b_safe;
    assign w_sq_mag = w_a_mag / w_b_mag;
    assign w_sr_mag = w_a_mag % w_b_mag;
    assign w_sq     = (A[31] ^ w_b_safe[31]) ? (32'd0 - w_sq_mag) : w_sq_mag;
    assign w_sr     = A[31] ? (32'd0 - w_sr_mag) : w_sr_mag;

    assign w_uq = A / w_b_safe;
    assign w_ur = A % w_b_safe;

    always_comb begin
        w_p_hi = 32'd0;
        w_p_lo = 32'd0;
        case (MDOp)
            c_OP_MULT:  {w_p_hi, w_p_lo} = w_smul;
            c_OP_MULTU: {w_p_hi, w_p_lo} = w_umul;
            c_OP_DIV:   begin w_p_hi = w_sr; w_p_lo = w_sq; end
            c_OP_DIVU:  begin w_p_hi = w_ur; w_p_lo = w_uq; end
            default:    begin w_p_hi = 32'd0; w_p_lo = 32'd0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_hi  <= 32'd0;
            r_lo  <= 32'd0;
            r_phi <= 32'd0;
            r_plo <= 32'd0;
            r_pdz <= 1'b0;
        end else if (!w_idle) begin
            // In flight: any Start is ignored until the countdown ends.
            r_cnt <= r_cnt - c_CNT_ONE;
            if ((r_cnt == c_CNT_ONE) && !r_pdz) begin
                r_hi <= r_phi;
                r_lo <= r_plo;
            end
        end else if (Start) begin
            if (w_is_md) begin
                r_phi <= w_p_hi;
                r_plo <= w_p_lo;
                r_pdz <= w_is_div && w_div_zero;
                r_cnt <= w_is_mul ? c_MULT_LOAD : c_DIV_LOAD;
            end else if (MDOp == c_OP_MTHI) begin
                r_hi <= A;
            end else if (MDOp == c_OP_MTLO) begin
                r_lo <= A;
            end
        end
    end

endmodule
`default_nettype wire
